imuldiv_int_div_iterative_param: RTL
====================================

Name: imuldiv_int_div_iterative_param

Overview:
Parametrised iterative restoring divider. It replaces the fixed 32-bit iterative divider in the imuldiv unit. It computes quotient and remainder of two W-bit operands, signed or unsigned, one quotient bit per cycle. It adds defined divide-by-zero results and an optional early-out path for trivial cases. It uses the same val/rdy request and response handshake as the other imuldiv units.

Parameters:
W, 32, operand width in bits; legal values are W >= 2.
EARLY_OUT, 1, 1 enables the single-cycle early-out path; 0 makes every operation take the full iterative latency.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
divreq_msg_fn  input  1  1 = signed divide, 0 = unsigned divide
divreq_msg_a  input  W  dividend
divreq_msg_b  input  W  divisor
divreq_val  input  1  request valid
divreq_rdy  output  1  request ready
divresp_msg_result  output  2W  {remainder[W-1:0], quotient[W-1:0]}
divresp_val  output  1  response valid
divresp_rdy  input  1  response ready

Behaviour:
- Reset, synchronous and active-high:
  - state <= IDLE, counter <= 0, result register <= 0.
  - Outputs after reset: divreq_rdy=1, divresp_val=0, divresp_msg_result=0.
- States:
  - IDLE: divreq_rdy=1, divresp_val=0.
  - CALC: both handshake outputs 0.
  - DONE: divresp_val=1, divreq_rdy=0.
- IDLE to next state, on divreq_val=1:
  - Latch fn, the sign of a, and the sign of (a XOR b).
  - Latch |a| and |b| as unsigned magnitudes; negation is applied only when fn=1 and the MSB is set.
  - Load a 2W+1-bit remainder/quotient register with {0, |a|} and the counter with W-1.
  - Go to CALC. If an early-out condition holds, go directly to DONE instead.
- Early-out conditions:
  - b==0: always applies, independent of EARLY_OUT.
  - |a| < |b|: applies only when EARLY_OUT=1.
- CALC, each cycle:
  - Shift the register left by 1 and subtract {|b|, W zeros}.
  - If the difference MSB is 0: keep the difference and set LSB=1. Otherwise keep the shifted value.
  - Decrement the counter. When counter==0 this cycle, go to DONE.
- Final sign fix-up, registered on entry to DONE:
  - quotient = negated if fn AND (a XOR b) sign bit.
  - remainder = negated if fn AND a sign bit.
  - Unsigned ops (fn=0) never negate.
- Result rules:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero: quotient = all ones (-1 when signed), remainder = a unmodified.
  - Signed overflow, a = -2^(W-1) and b = -1: quotient = -2^(W-1), remainder = 0. No exception is raised.
  - Early-out |a|<|b|: quotient = 0, remainder = a unmodified.
- Latency, counting the request handshake cycle as cycle 0:
  - Normal operation: divresp_val first high in cycle W+1.
  - Early-out: divresp_val first high in cycle 1.
- DONE:
  - divresp_msg_result is held stable for as long as divresp_val=1.
  - On divresp_val AND divresp_rdy, go to IDLE. The next request can be accepted the cycle after that.
  - divresp_rdy is ignored outside DONE.
- Input stability: request inputs are sampled only on the handshake cycle. Operand changes during CALC or DONE have no effect.
- Back-to-back operation: there is no overlap between transactions; throughput is one operation per W+2 cycles minimum.
- Reset mid-operation, in CALC or DONE: the block returns to IDLE on the next edge. The in-flight result is discarded and divresp_val is never asserted for it.
- Response output in IDLE/CALC: divresp_msg_result shows the last registered result and is a don't-care.

Test Plan:
1. W=32, fn=0, a=100, b=7 -> result {rem 2, quo 14}; divresp_val rises exactly 33 cycles after the accept cycle. Also check divreq_rdy=0 throughout.
2. W=32, fn=1, each of the four sign combinations of 7 and 2 -> quo/rem:
   - a=-7, b=2 -> -3/-1
   - a=7, b=-2 -> -3/1
   - a=-7, b=-2 -> 3/-1
   - a=7, b=2 -> 3/1
3. W=32, fn=1: a=0x80000000, b=0xFFFFFFFF -> quo 0x80000000, rem 0. Then fn=0, a=0xFFFFFFFF, b=1 -> quo 0xFFFFFFFF, rem 0.
4. Divide by zero, a=0x1234 with b=0 under fn=0 and fn=1 -> quo 0xFFFFFFFF, rem 0x1234, val in cycle 1. Separately, EARLY_OUT=1 with a=3, b=9 -> quo 0, rem 3 in cycle 1. With EARLY_OUT=0 the a=3, b=9 case gives the same result in cycle 33.
5. Hold divresp_rdy=0 for 10 cycles in DONE -> result is stable and divreq_rdy stays 0. Raise divresp_rdy -> IDLE next cycle. Issue a back-to-back request immediately -> it is accepted.
6. Assert reset at CALC cycle 10 -> IDLE with divreq_rdy=1 and divresp_val=0 next cycle; no stale response appears. Repeat tests 1 and 3 with W=8 and W=16 (e.g. W=8 signed: a=-128, b=3 -> quo -42, rem -2), and run a randomised comparison against a reference model.

Source files
------------

// File: rtl/imuldiv_int_div_iterative_param.sv
// Iterative restoring divider: one quotient bit per cycle, signed or unsigned,
// with defined divide-by-zero results and an optional early-out for |a| < |b|.
module imuldiv_int_div_iterative_param #(
  parameter int W         = 32,
  parameter int EARLY_OUT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           divreq_msg_fn,
  input  logic [W-1:0]   divreq_msg_a,
  input  logic [W-1:0]   divreq_msg_b,
  input  logic           divreq_val,
  output logic           divreq_rdy,
  output logic [2*W-1:0] divresp_msg_result,
  output logic           divresp_val,
  input  logic           divresp_rdy
);
  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_rq;
  logic [W-1:0]   r_b_mag;
  logic           r_neg_q;
  logic           r_neg_r;
  logic [2*W-1:0] r_result;

  logic [W-1:0]   w_a_mag;
  logic [W-1:0]   w_b_mag;
  logic           w_b_zero;
  logic           w_early;
  logic [2*W:0]   w_shift;
  logic [2*W:0]   w_diff;
  logic [2*W-1:0] w_rq_step;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_rem;

  assign w_a_mag  = (divreq_msg_fn && divreq_msg_a[W-1]) ? -divreq_msg_a : divreq_msg_a;
  assign w_b_mag  = (divreq_msg_fn && divreq_msg_b[W-1]) ? -divreq_msg_b : divreq_msg_b;
  assign w_b_zero = (divreq_msg_b == '0);
  assign w_early  = w_b_zero || ((EARLY_OUT != 0) && (w_a_mag < w_b_mag));

  // One restoring step: the difference's top bit set means the trial subtract underflowed.
  assign w_shift   = {r_rq, 1'b0};
  assign w_diff    = w_shift - {1'b0, r_b_mag, {W{1'b0}}};
  assign w_rq_step = w_diff[2*W] ? w_shift[2*W-1:0]
                                 : (w_diff[2*W-1:0] | {{(2*W-1){1'b0}}, 1'b1});
  assign w_quo     = r_neg_q ? -w_rq_step[W-1:0]   : w_rq_step[W-1:0];
  assign w_rem     = r_neg_r ? -w_rq_step[2*W-1:W] : w_rq_step[2*W-1:W];

  always_comb begin
    w_state_next = r_state;
    divreq_rdy   = 1'b0;
    divresp_val  = 1'b0;
    case (r_state)
      IDLE: begin
        divreq_rdy = 1'b1;
        if (divreq_val) w_state_next = w_early ? DONE : CALC;
      end
      CALC: begin
        if (r_cnt == '0) w_state_next = DONE;
      end
      DONE: begin
        divresp_val = 1'b1;
        if (divresp_rdy) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rq     <= '0;
      r_b_mag  <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (divreq_val) begin
            r_rq    <= {{W{1'b0}}, w_a_mag};
            r_b_mag <= w_b_mag;
            r_cnt   <= CW'(W - 1);
            r_neg_q <= divreq_msg_fn & (divreq_msg_a[W-1] ^ divreq_msg_b[W-1]);
            r_neg_r <= divreq_msg_fn & divreq_msg_a[W-1];
            // Trivial cases skip the iteration; the remainder is the raw dividend.
            if (w_b_zero)     r_result <= {divreq_msg_a, {W{1'b1}}};
            else if (w_early) r_result <= {divreq_msg_a, {W{1'b0}}};
          end
        end
        CALC: begin
          r_rq  <= w_rq_step;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) r_result <= {w_rem, w_quo};
        end
        default: ;
      endcase
    end
  end

  assign divresp_msg_result = r_result;

endmodule
